// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder: byte-lane codes,
// byte-enable legality check and lane merging.
package dmem_pkg;

  localparam int BYTE_LANES = 4;
  localparam int WORD_W     = 8 * BYTE_LANES;

  localparam logic [BYTE_LANES-1:0] BE_B0 = 4'b0001;
  localparam logic [BYTE_LANES-1:0] BE_B1 = 4'b0010;
  localparam logic [BYTE_LANES-1:0] BE_B2 = 4'b0100;
  localparam logic [BYTE_LANES-1:0] BE_B3 = 4'b1000;
  localparam logic [BYTE_LANES-1:0] BE_H0 = 4'b0011;
  localparam logic [BYTE_LANES-1:0] BE_H1 = 4'b1100;
  localparam logic [BYTE_LANES-1:0] BE_W  = 4'b1111;

  function automatic logic be_legal(input logic [BYTE_LANES-1:0] be);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: be_legal = 1'b1;
      default:                                         be_legal = 1'b0;
    endcase
  endfunction

  // Lanes with be=1 take new_w, the rest keep old_w.
  function automatic logic [WORD_W-1:0] lane_merge(input logic [WORD_W-1:0]     old_w,
                                                   input logic [WORD_W-1:0]     new_w,
                                                   input logic [BYTE_LANES-1:0] be);
    logic [WORD_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_wbuf_responder_if.sv
// CPU data-bus interface between the CPU (master) and the data memory (slave).
interface dmem_wbuf_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic                  RD;
  logic                  WR;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [3:0]            byte_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  buf_valid;
  logic                  err;

  modport master (
    output RD, WR, addr, data_in, byte_en, err_clr,
    input  data_out, buf_valid, err
  );

  modport slave (
    input  RD, WR, addr, data_in, byte_en, err_clr,
    output data_out, buf_valid, err
  );
endinterface

// File: rtl/dmem_wbuf_responder_wbuf_entry.sv
// One-entry posted write buffer: holds {valid, idx, data, be} and produces the
// array word with buffered lanes forwarded when the lookup index matches.
module wbuf_entry
  import dmem_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic                  drain,
  input  logic [IDX_W-1:0]      cap_idx,
  input  logic [WORD_W-1:0]     cap_data,
  input  logic [BYTE_LANES-1:0] cap_be,
  input  logic [IDX_W-1:0]      lookup_idx,
  input  logic [WORD_W-1:0]     lookup_data,
  output logic                  valid,
  output logic [IDX_W-1:0]      idx,
  output logic [WORD_W-1:0]     data,
  output logic [BYTE_LANES-1:0] be,
  output logic [WORD_W-1:0]     fwd_data
);

  logic                  valid_d, valid_q;
  logic [IDX_W-1:0]      idx_d, idx_q;
  logic [WORD_W-1:0]     data_d, data_q;
  logic [BYTE_LANES-1:0] be_d, be_q;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    be_d    = be_q;
    if (capture) begin
      valid_d = 1'b1;
      idx_d   = cap_idx;
      data_d  = cap_data;
      be_d    = cap_be;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Only the valid bit is reset; the payload is meaningless while invalid.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
    idx_q  <= idx_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  assign valid    = valid_q;
  assign idx      = idx_q;
  assign data     = data_q;
  assign be       = be_q;
  assign fwd_data = (valid_q && (idx_q == lookup_idx)) ? lane_merge(lookup_data, data_q, be_q)
                                                       : lookup_data;

endmodule

// File: rtl/dmem_wbuf_responder.sv
// Data-memory responder: word array behind a posted write buffer with
// read-after-write forwarding, 1-cycle load latency and a sticky error flag.
module dmem_wbuf_responder
  import dmem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_wbuf_responder_if.slave  bus
);

  localparam int                    IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH) << 2;

  logic [WORD_W-1:0]     mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic [WORD_W-1:0]     rd_word;

  logic                  capture, drain, commit, err_new;
  logic [WORD_W-1:0]     data_out_d, data_out_q;
  logic                  err_d, err_q;

  logic                  buf_valid;
  logic [IDX_W-1:0]      buf_idx;
  logic [WORD_W-1:0]     buf_data;
  logic [BYTE_LANES-1:0] buf_be;
  logic [WORD_W-1:0]     fwd_data;

  assign offset   = bus.addr - BASE_ADDR;
  assign in_range = (bus.addr >= BASE_ADDR) && (offset < SPAN);
  assign idx      = offset[IDX_W+1:2];
  assign rd_word  = mem_q[idx];

  wbuf_entry #(.IDX_W(IDX_W)) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .capture     (capture),
    .drain       (drain),
    .cap_idx     (idx),
    .cap_data    (bus.data_in),
    .cap_be      (bus.byte_en),
    .lookup_idx  (idx),
    .lookup_data (rd_word),
    .valid       (buf_valid),
    .idx         (buf_idx),
    .data        (buf_data),
    .be          (buf_be),
    .fwd_data    (fwd_data)
  );

  // Priority: illegal lanes > out of range > write (with RD conflict) > read > idle.
  always_comb begin
    capture    = 1'b0;
    drain      = 1'b0;
    err_new    = 1'b0;
    data_out_d = data_out_q;
    if ((bus.RD || bus.WR) && !be_legal(bus.byte_en)) begin
      err_new = 1'b1;
      if (bus.RD) data_out_d = '0;
    end else if ((bus.RD || bus.WR) && !in_range) begin
      err_new = 1'b1;
      drain   = buf_valid;
      if (bus.RD) data_out_d = '0;
    end else if (bus.WR) begin
      capture = 1'b1;
      if (bus.RD) begin
        err_new    = 1'b1;
        data_out_d = '0;
      end
    end else if (bus.RD) begin
      data_out_d = fwd_data;
    end else begin
      drain = buf_valid;
    end
    err_d = err_new | (err_q & ~bus.err_clr);
  end

  // The old entry retires whenever it is replaced or drained; reset discards it.
  assign commit = buf_valid & (capture | drain) & ~rst;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (buf_be[i]) mem_q[buf_idx][8*i +: 8] <= buf_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.buf_valid = buf_valid;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Directed bench for dmem_wbuf_responder with hand-computed expectations.
module tb_dmem_wbuf_responder;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  dmem_wbuf_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  dmem_wbuf_responder #(
    .DATA_WIDTH (32),
    .DEPTH      (256),
    .ADDR_WIDTH (32),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, input logic clr);
    bus.RD      = rd;
    bus.WR      = wr;
    bus.addr    = a;
    bus.data_in = d;
    bus.byte_en = be;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle();
    idle();
    check("reset_data_out", bus.data_out, 32'h0);
    check("reset_buf_valid", 32'(bus.buf_valid), 32'h0);
    check("reset_err", 32'(bus.err), 32'h0);
    rst = 1'b0;

    // Full-word store then forwarded load
    step(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    check("wr_buf_valid", 32'(bus.buf_valid), 32'h1);
    step(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
    check("fwd_full", bus.data_out, 32'hDEAD_BEEF);
    check("fwd_buf_hold", 32'(bus.buf_valid), 32'h1);
    idle();
    check("drain_buf_valid", 32'(bus.buf_valid), 32'h0);
    check("idle_hold_data", bus.data_out, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
    check("array_full", bus.data_out, 32'hDEAD_BEEF);

    // Partial store forwarding
    step(1'b0, 1'b1, 32'h10, 32'h1122_3344, 4'b1111, 1'b0);
    idle();
    step(1'b0, 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 1'b0);
    step(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
    check("fwd_partial", bus.data_out, 32'h1122_AA44);
    idle();
    check("partial_drained", 32'(bus.buf_valid), 32'h0);
    step(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
    check("array_partial", bus.data_out, 32'h1122_AA44);

    // Consecutive stores with a same-index merge
    step(1'b0, 1'b1, 32'h20, 32'h0000_0001, 4'b1111, 1'b0);
    step(1'b0, 1'b1, 32'h24, 32'h0000_0002, 4'b1111, 1'b0);
    step(1'b0, 1'b1, 32'h20, 32'hFF00_0000, 4'b1000, 1'b0);
    step(1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0);
    check("fwd_merge", bus.data_out, 32'hFF00_0001);
    idle();
    step(1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0);
    check("array_merge_8", bus.data_out, 32'hFF00_0001);
    step(1'b1, 1'b0, 32'h24, 32'h0, 4'b0011, 1'b0);
    check("array_9", bus.data_out, 32'h0000_0002);
    check("no_err_yet", 32'(bus.err), 32'h0);

    // RD and WR together
    step(1'b1, 1'b1, 32'h30, 32'h1234_5678, 4'b1111, 1'b0);
    check("rdwr_err", 32'(bus.err), 32'h1);
    check("rdwr_data_out", bus.data_out, 32'h0);
    check("rdwr_buffered", 32'(bus.buf_valid), 32'h1);
    idle();
    step(1'b1, 1'b0, 32'h30, 32'h0, 4'b1111, 1'b0);
    check("rdwr_write_landed", bus.data_out, 32'h1234_5678);

    // Illegal byte enable leaves the pending buffer untouched
    step(1'b0, 1'b1, 32'h34, 32'hCAFE_F00D, 4'b1111, 1'b0);
    step(1'b0, 1'b1, 32'h34, 32'h0000_AAAA, 4'b0101, 1'b0);
    check("badbe_err", 32'(bus.err), 32'h1);
    check("badbe_no_drain", 32'(bus.buf_valid), 32'h1);
    check("badbe_wr_hold", bus.data_out, 32'h1234_5678);
    idle();
    step(1'b1, 1'b0, 32'h34, 32'h0, 4'b1111, 1'b0);
    check("badbe_dropped", bus.data_out, 32'hCAFE_F00D);

    // Error clear, and clear losing to a simultaneous error
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1);
    check("err_clr", 32'(bus.err), 32'h0);
    step(1'b1, 1'b0, 32'h30, 32'h0, 4'b0101, 1'b1);
    check("clr_vs_err", 32'(bus.err), 32'h1);
    check("badbe_rd_zero", bus.data_out, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1);
    check("err_clr2", 32'(bus.err), 32'h0);

    // Out-of-range read drains a pending store
    step(1'b0, 1'b1, 32'h38, 32'h0000_0077, 4'b1111, 1'b0);
    step(1'b1, 1'b0, 32'h400, 32'h0, 4'b1111, 1'b0);
    check("oor_data_out", bus.data_out, 32'h0);
    check("oor_err", 32'(bus.err), 32'h1);
    check("oor_drain", 32'(bus.buf_valid), 32'h0);
    step(1'b1, 1'b0, 32'h38, 32'h0, 4'b1111, 1'b0);
    check("oor_drained_value", bus.data_out, 32'h0000_0077);

    // Reset discards a pending store
    step(1'b0, 1'b1, 32'h40, 32'h1357_2468, 4'b1111, 1'b0);
    idle();
    step(1'b0, 1'b1, 32'h40, 32'h0000_0055, 4'b1111, 1'b0);
    rst = 1'b1;
    idle();
    check("rst_buf_valid", 32'(bus.buf_valid), 32'h0);
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    rst = 1'b0;
    step(1'b1, 1'b0, 32'h40, 32'h0, 4'b1111, 1'b0);
    check("rst_store_lost", bus.data_out, 32'h1357_2468);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
